// File: rtl/invader_formation.sv
// invader_formation: ROWS x COLS alien grid kept as one shared origin plus an
// alive bitmap. Marches left/right, drops at the screen edges, resolves rocket
// hits with a one-cycle request/done handshake and answers render queries.
// Optional build macro FORMATION_SPEEDUP_EN: the step period tracks the live
// alien count, so the formation speeds up as it is thinned out.
module invader_formation #(
  parameter int ROWS       = 3,
  parameter int COLS       = 6,
  parameter int SPACING_X  = 40,
  parameter int SPACING_Y  = 32,
  parameter int ALIEN_W    = 16,
  parameter int START_X    = 80,
  parameter int START_Y    = 40,
  parameter int STEP_X     = 2,
  parameter int DROP_Y     = 16,
  parameter int SCREEN_W   = 640,
  parameter int LAND_Y     = 428,
  parameter int MIN_PERIOD = 20000,
  parameter int PER_ALIEN  = 8192,
  parameter int CNT_W      = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 restart,
  input  logic                 hit_valid,
  input  logic [9:0]           hit_x,
  input  logic [9:0]           hit_y,
  output logic                 hit_done,
  output logic                 hit_kill,
  output logic [5:0]           hit_index,
  output logic [3:0]           hit_points,
  input  logic [9:0]           pix_x,
  input  logic [9:0]           pix_y,
  output logic                 pix_alien,
  output logic [9:0]           pix_ox,
  output logic [9:0]           pix_oy,
  output logic [9:0]           origin_x,
  output logic [9:0]           origin_y,
  output logic [ROWS*COLS-1:0] alive,
  output logic [6:0]           alive_count,
  output logic                 step_pulse,
  output logic                 landed,
  output logic                 cleared
);

  localparam int N = ROWS * COLS;

  typedef enum logic {MARCH = 1'b0, HALT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [9:0]       origin_x_q, origin_x_d, origin_y_q, origin_y_d;
  logic             dir_right_q, dir_right_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [6:0]       alive_count_q, alive_count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_pulse_q, step_pulse_d;
  logic             landed_q, landed_d, cleared_q, cleared_d;
  logic             hit_done_q, hit_done_d, hit_kill_q, hit_kill_d;
  logic [5:0]       hit_index_q, hit_index_d;
  logic [3:0]       hit_points_q, hit_points_d;
  logic             pix_alien_q, pix_alien_d;
  logic [9:0]       pix_ox_q, pix_ox_d, pix_oy_q, pix_oy_d;

  logic             march;
  logic             hit_found, pix_found;
  logic [N-1:0]     kill_mask;
  logic [5:0]       hit_sel;
  logic [3:0]       hit_pts;
  logic [9:0]       pix_ax, pix_ay;
  logic [COLS-1:0]  col_live;
  logic [ROWS-1:0]  row_live;
  logic [10:0]      cmin_off, cmax_off, rmax_off;
  logic [10:0]      right_edge, left_edge, new_y;
  logic             drop, land, count_en, step_now;
  logic [CNT_W-1:0] period_m1;

  // True when (qx,qy) lies inside the sprite box of alien idx for the given origin.
  function automatic logic covers(input int idx, input logic [9:0] ox, input logic [9:0] oy,
                                  input logic [9:0] qx, input logic [9:0] qy);
    logic [10:0] ax, ay;
    ax = {1'b0, ox} + 11'((idx % COLS) * SPACING_X);
    ay = {1'b0, oy} + 11'((idx / COLS) * SPACING_Y);
    return ({1'b0, qx} >= ax) && ({1'b0, qx} < ax + 11'(ALIEN_W)) &&
           ({1'b0, qy} >= ay) && ({1'b0, qy} < ay + 11'(ALIEN_W));
  endfunction

`ifdef FORMATION_SPEEDUP_EN
  assign period_m1 = CNT_W'(MIN_PERIOD) + CNT_W'(PER_ALIEN) * CNT_W'(alive_count_q) - CNT_W'(1);
`else
  localparam int PERIOD_FIXED = MIN_PERIOD + PER_ALIEN * N;
  assign period_m1 = CNT_W'(PERIOD_FIXED - 1);
`endif

  // Lowest-index live alien under the rocket probe; descending scan so index 0 wins.
  always_comb begin
    hit_found = 1'b0;
    hit_sel   = '0;
    hit_pts   = '0;
    kill_mask = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (alive_q[i] && covers(i, origin_x_q, origin_y_q, hit_x, hit_y)) begin
        hit_found    = 1'b1;
        hit_sel      = 6'(i);
        hit_pts      = 4'(ROWS - i / COLS);
        kill_mask    = '0;
        kill_mask[i] = 1'b1;
      end
    end
  end

  // Lowest-index live alien under the render query pixel.
  always_comb begin
    pix_found = 1'b0;
    pix_ax    = '0;
    pix_ay    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (alive_q[i] && covers(i, origin_x_q, origin_y_q, pix_x, pix_y)) begin
        pix_found = 1'b1;
        pix_ax    = 10'({1'b0, origin_x_q} + 11'((i % COLS) * SPACING_X));
        pix_ay    = 10'({1'b0, origin_y_q} + 11'((i / COLS) * SPACING_Y));
      end
    end
  end

  // Pixel offsets of the leftmost/rightmost live columns and the lowest live row.
  always_comb begin
    col_live = '0;
    row_live = '0;
    for (int i = 0; i < N; i++) begin
      if (alive_q[i]) begin
        col_live[i % COLS] = 1'b1;
        row_live[i / COLS] = 1'b1;
      end
    end
    cmin_off = '0;
    cmax_off = '0;
    rmax_off = '0;
    for (int c = COLS - 1; c >= 0; c--) if (col_live[c]) cmin_off = 11'(c * SPACING_X);
    for (int c = 0; c < COLS; c++)      if (col_live[c]) cmax_off = 11'(c * SPACING_X);
    for (int r = 0; r < ROWS; r++)      if (row_live[r]) rmax_off = 11'(r * SPACING_Y);
  end

  assign right_edge = {1'b0, origin_x_q} + cmax_off + 11'(ALIEN_W) + 11'(STEP_X);
  assign left_edge  = {1'b0, origin_x_q} + cmin_off;
  assign drop       = dir_right_q ? (right_edge > 11'(SCREEN_W)) : (left_edge < 11'(STEP_X));
  assign new_y      = {1'b0, origin_y_q} + 11'(DROP_Y);
  assign land       = (new_y + rmax_off + 11'(ALIEN_W)) >= 11'(LAND_Y);
  assign count_en   = enable && march;
  assign step_now   = count_en && (cnt_q >= period_m1);

  // Next formation state: restart first, then hit (pre-step origin), then march step.
  always_comb begin
    origin_x_d    = origin_x_q;
    origin_y_d    = origin_y_q;
    dir_right_d   = dir_right_q;
    alive_d       = alive_q;
    alive_count_d = alive_count_q;
    cnt_d         = cnt_q;
    landed_d      = landed_q;
    cleared_d     = cleared_q;
    step_pulse_d  = 1'b0;
    hit_done_d    = 1'b0;
    hit_kill_d    = 1'b0;
    hit_index_d   = '0;
    hit_points_d  = '0;
    pix_alien_d   = 1'b0;
    pix_ox_d      = '0;
    pix_oy_d      = '0;
    if (restart) begin
      origin_x_d    = 10'(START_X);
      origin_y_d    = 10'(START_Y);
      dir_right_d   = 1'b1;
      alive_d       = '1;
      alive_count_d = 7'(N);
      cnt_d         = '0;
      landed_d      = 1'b0;
      cleared_d     = 1'b0;
    end else begin
      pix_alien_d = pix_found;
      pix_ox_d    = pix_ax;
      pix_oy_d    = pix_ay;
      hit_done_d  = hit_valid;
      if (hit_valid && march && hit_found) begin
        hit_kill_d    = 1'b1;
        hit_index_d   = hit_sel;
        hit_points_d  = hit_pts;
        alive_d       = alive_q & ~kill_mask;
        alive_count_d = alive_count_q - 7'd1;
        if (alive_count_q == 7'd1) cleared_d = 1'b1;
      end
      if (count_en) begin
        if (step_now) begin
          cnt_d        = '0;
          step_pulse_d = 1'b1;
          if (drop) begin
            origin_y_d  = new_y[9:0];
            dir_right_d = !dir_right_q;
            if (land) landed_d = 1'b1;
          end else if (dir_right_q) begin
            origin_x_d = origin_x_q + 10'(STEP_X);
          end else begin
            origin_x_d = origin_x_q - 10'(STEP_X);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // FSM next state: halt once the formation lands or is wiped out.
  always_comb begin
    state_d = state_q;
    if (restart) state_d = MARCH;
    else if (state_q == MARCH && (landed_d || cleared_d)) state_d = HALT;
  end

  // FSM outputs: marching enables steps and kills.
  always_comb begin
    march = (state_q == MARCH);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MARCH;
    else       state_q <= state_d;
  end

  // Formation, handshake and render registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      origin_x_q    <= 10'(START_X);
      origin_y_q    <= 10'(START_Y);
      dir_right_q   <= 1'b1;
      alive_q       <= '1;
      alive_count_q <= 7'(N);
      cnt_q         <= '0;
      step_pulse_q  <= 1'b0;
      landed_q      <= 1'b0;
      cleared_q     <= 1'b0;
      hit_done_q    <= 1'b0;
      hit_kill_q    <= 1'b0;
      hit_index_q   <= '0;
      hit_points_q  <= '0;
      pix_alien_q   <= 1'b0;
      pix_ox_q      <= '0;
      pix_oy_q      <= '0;
    end else begin
      origin_x_q    <= origin_x_d;
      origin_y_q    <= origin_y_d;
      dir_right_q   <= dir_right_d;
      alive_q       <= alive_d;
      alive_count_q <= alive_count_d;
      cnt_q         <= cnt_d;
      step_pulse_q  <= step_pulse_d;
      landed_q      <= landed_d;
      cleared_q     <= cleared_d;
      hit_done_q    <= hit_done_d;
      hit_kill_q    <= hit_kill_d;
      hit_index_q   <= hit_index_d;
      hit_points_q  <= hit_points_d;
      pix_alien_q   <= pix_alien_d;
      pix_ox_q      <= pix_ox_d;
      pix_oy_q      <= pix_oy_d;
    end
  end

  assign origin_x    = origin_x_q;
  assign origin_y    = origin_y_q;
  assign alive       = alive_q;
  assign alive_count = alive_count_q;
  assign step_pulse  = step_pulse_q;
  assign landed      = landed_q;
  assign cleared     = cleared_q;
  assign hit_done    = hit_done_q;
  assign hit_kill    = hit_kill_q;
  assign hit_index   = hit_index_q;
  assign hit_points  = hit_points_q;
  assign pix_alien   = pix_alien_q;
  assign pix_ox      = pix_ox_q;
  assign pix_oy      = pix_oy_q;

endmodule

// File: tb/tb_invader_formation.sv
// Testbench for invader_formation: randomized render/hit stimulus compared each
// cycle against a behavioural formation model, plus directed scenario checks.
// A short period and a raised landing line keep the march scenarios brief.
module tb_invader_formation;

  localparam int ROWS = 3, COLS = 6, NA = ROWS * COLS;
  localparam int SPACING_X = 40, SPACING_Y = 32, ALIEN_W = 16;
  localparam int START_X = 80, START_Y = 40, STEP_X = 2, DROP_Y = 16;
  localparam int SCREEN_W = 640, LAND_Y = 140, MIN_PERIOD = 4, PER_ALIEN = 1;

  logic clk = 1'b0;
  logic reset, enable, restart, hit_valid;
  logic [9:0] hit_x, hit_y, pix_x, pix_y;
  logic hit_done, hit_kill, pix_alien, step_pulse, landed, cleared;
  logic [5:0] hit_index;
  logic [3:0] hit_points;
  logic [9:0] pix_ox, pix_oy, origin_x, origin_y;
  logic [NA-1:0] alive;
  logic [6:0] alive_count;

  invader_formation #(
    .ROWS(ROWS), .COLS(COLS), .SPACING_X(SPACING_X), .SPACING_Y(SPACING_Y),
    .ALIEN_W(ALIEN_W), .START_X(START_X), .START_Y(START_Y), .STEP_X(STEP_X),
    .DROP_Y(DROP_Y), .SCREEN_W(SCREEN_W), .LAND_Y(LAND_Y),
    .MIN_PERIOD(MIN_PERIOD), .PER_ALIEN(PER_ALIEN), .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .hit_done(hit_done), .hit_kill(hit_kill), .hit_index(hit_index), .hit_points(hit_points),
    .pix_x(pix_x), .pix_y(pix_y), .pix_alien(pix_alien), .pix_ox(pix_ox), .pix_oy(pix_oy),
    .origin_x(origin_x), .origin_y(origin_y), .alive(alive), .alive_count(alive_count),
    .step_pulse(step_pulse), .landed(landed), .cleared(cleared)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model of the formation.
  int m_ox, m_oy, m_cnt, m_idx, m_pts, m_pox, m_poy;
  bit m_right, m_halt, m_landed, m_cleared, m_step, m_done, m_kill, m_pa;
  logic [63:0] m_alive;

  function automatic int popc(input logic [63:0] v);
    int s = 0;
    for (int i = 0; i < 64; i++) s += int'(v[i]);
    return s;
  endfunction

  function automatic bit in_alien(input int i, input int ox, input int oy, input int qx, input int qy);
    int ax = ox + (i % COLS) * SPACING_X;
    int ay = oy + (i / COLS) * SPACING_Y;
    return (qx >= ax) && (qx < ax + ALIEN_W) && (qy >= ay) && (qy < ay + ALIEN_W);
  endfunction

  task automatic model_reset();
    m_ox = START_X; m_oy = START_Y; m_right = 1; m_alive = (64'd1 << NA) - 64'd1;
    m_cnt = 0; m_halt = 0; m_landed = 0; m_cleared = 0; m_step = 0;
    m_done = 0; m_kill = 0; m_idx = 0; m_pts = 0; m_pa = 0; m_pox = 0; m_poy = 0;
  endtask

  task automatic model_step();
    logic [63:0] na;
    int per, cmin, cmax, rmax;
    bit drop;
    if (restart) begin
      model_reset();
      return;
    end
    m_pa = 0; m_pox = 0; m_poy = 0;
    for (int i = 0; i < NA; i++)
      if (!m_pa && m_alive[i] && in_alien(i, m_ox, m_oy, int'(pix_x), int'(pix_y))) begin
        m_pa = 1; m_pox = m_ox + (i % COLS) * SPACING_X; m_poy = m_oy + (i / COLS) * SPACING_Y;
      end
    m_done = hit_valid; m_kill = 0; m_idx = 0; m_pts = 0; na = m_alive;
    if (hit_valid && !m_halt)
      for (int i = 0; i < NA; i++)
        if (!m_kill && m_alive[i] && in_alien(i, m_ox, m_oy, int'(hit_x), int'(hit_y))) begin
          m_kill = 1; m_idx = i; m_pts = ROWS - i / COLS; na[i] = 1'b0;
        end
    m_step = 0;
    if (enable && !m_halt) begin
`ifdef FORMATION_SPEEDUP_EN
      per = MIN_PERIOD + PER_ALIEN * popc(m_alive);
`else
      per = MIN_PERIOD + PER_ALIEN * NA;
`endif
      if (m_cnt >= per - 1) begin m_cnt = 0; m_step = 1; end
      else m_cnt++;
    end
    if (m_step) begin
      cmin = COLS; cmax = 0; rmax = 0; drop = 0;
      for (int i = 0; i < NA; i++)
        if (m_alive[i]) begin
          if (i % COLS < cmin) cmin = i % COLS;
          if (i % COLS > cmax) cmax = i % COLS;
          if (i / COLS > rmax) rmax = i / COLS;
        end
      if (m_right) begin
        if (m_ox + cmax * SPACING_X + ALIEN_W + STEP_X > SCREEN_W) drop = 1;
        else m_ox += STEP_X;
      end else begin
        if (m_ox + cmin * SPACING_X < STEP_X) drop = 1;
        else m_ox -= STEP_X;
      end
      if (drop) begin
        m_oy += DROP_Y;
        m_right = !m_right;
        if (m_oy + rmax * SPACING_Y + ALIEN_W >= LAND_Y) begin m_landed = 1; m_halt = 1; end
      end
    end
    m_alive = na;
    if (m_kill && popc(na) == 0) begin m_cleared = 1; m_halt = 1; end
  endtask

  task automatic compare_all();
    check("origin_x", origin_x, m_ox);
    check("origin_y", origin_y, m_oy);
    check("alive", 64'(alive), m_alive);
    check("alive_count", alive_count, popc(m_alive));
    check("step_pulse", step_pulse, m_step);
    check("landed", landed, m_landed);
    check("cleared", cleared, m_cleared);
    check("hit_done", hit_done, m_done);
    check("hit_kill", hit_kill, m_kill);
    check("hit_index", hit_index, m_idx);
    check("hit_points", hit_points, m_pts);
    check("pix_alien", pix_alien, m_pa);
    check("pix_ox", pix_ox, m_pox);
    check("pix_oy", pix_oy, m_poy);
  endtask

  function automatic logic [9:0] near(input int base);
    int v = base + int'($urandom_range(0, 21)) - 3;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return 10'(v);
  endfunction

  task automatic tick();
    int i;
    if ($urandom_range(0, 1) == 0) begin
      i = int'($urandom_range(0, NA - 1));
      pix_x = near(m_ox + (i % COLS) * SPACING_X);
      pix_y = near(m_oy + (i / COLS) * SPACING_Y);
    end else begin
      pix_x = 10'($urandom_range(0, 1023));
      pix_y = 10'($urandom_range(0, 1023));
    end
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_hit(input int x, input int y);
    hit_valid = 1'b1; hit_x = 10'(x); hit_y = 10'(y);
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin tick(); n++; end while (!step_pulse && n < 2000);
    check("step_seen", step_pulse, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ox"}, origin_x, START_X);
    check({tag, "_oy"}, origin_y, START_Y);
    check({tag, "_alive"}, 64'(alive), 64'h3FFFF);
    check({tag, "_count"}, alive_count, 18);
    check({tag, "_landed"}, landed, 0);
    check({tag, "_cleared"}, cleared, 0);
    check({tag, "_hit_done"}, hit_done, 0);
    check({tag, "_hit_kill"}, hit_kill, 0);
    check({tag, "_step"}, step_pulse, 0);
    check({tag, "_pix"}, pix_alien, 0);
  endtask

  // Restart together with a live hit request: restart must win.
  task automatic do_restart(input string tag);
    restart = 1'b1; hit_valid = 1'b1; hit_x = 10'd85; hit_y = 10'd45;
    tick();
    restart = 1'b0; hit_valid = 1'b0;
    check_reset_vals(tag);
  endtask

  initial begin
    int n, k, i;
    reset = 1'b1; enable = 1'b0; restart = 1'b0; hit_valid = 1'b0;
    hit_x = '0; hit_y = '0; pix_x = '0; pix_y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // First step timing and position.
    enable = 1'b1;
    wait_step(n);
    check("first_step_cycle", n, 22);
    check("first_step_ox", origin_x, 82);

    // Single hit and a miss.
    do_hit(85, 45);
    check("hit_a_done", hit_done, 1);
    check("hit_a_kill", hit_kill, 1);
    check("hit_a_index", hit_index, 0);
    check("hit_a_points", hit_points, 3);
    check("hit_a_bit0", alive[0], 0);
    check("hit_a_count", alive_count, 17);
    do_hit(96, 45);
    check("miss_done", hit_done, 1);
    check("miss_kill", hit_kill, 0);
    check("miss_points", hit_points, 0);

    // Period after one kill.
    wait_step(n);
    wait_step(n);
`ifdef FORMATION_SPEEDUP_EN
    check("period_after_kill", n, 21);
`else
    check("period_after_kill", n, 22);
`endif

    // Full grid march to the right edge, drop, reverse.
    do_restart("restart_a");
    enable = 1'b1;
    k = 0;
    while (m_ox != 424 && k < 300) begin wait_step(n); k++; end
    check("reach_424_x", origin_x, 424);
    check("reach_424_y", origin_y, 40);
    wait_step(n);
    check("drop_y", origin_y, 56);
    check("drop_x", origin_x, 424);
    wait_step(n);
    check("after_drop_x", origin_x, 422);

    // Column 5 destroyed: drop moves further right; then march down to landing.
    do_restart("restart_b");
    enable = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      do_hit(START_X + 5 * SPACING_X + 5, START_Y + r * SPACING_Y + 5);
      check("col5_kill", hit_kill, 1);
      check("col5_index", hit_index, 5 + r * COLS);
    end
    check("col5_count", alive_count, 15);
    enable = 1'b1;
    k = 0;
    while (m_oy == START_Y && k < 400) begin wait_step(n); k++; end
    check("col5_drop_x", origin_x, 464);
    check("col5_drop_y", origin_y, 56);
    while (!m_landed && k < 1000) begin wait_step(n); k++; end
    check("landed_flag", landed, 1);
    check("landed_y", origin_y, 72);
    check("landed_x", origin_x, 0);
    n = 0;
    repeat (100) begin tick(); if (step_pulse) n++; end
    check("halt_no_steps", n, 0);
    do_hit(5, 77);
    check("halt_hit_done", hit_done, 1);
    check("halt_hit_kill", hit_kill, 0);
    check("halt_count", alive_count, 15);

    // Clear the whole grid.
    do_restart("restart_c");
    enable = 1'b0;
    for (int a = 0; a < NA; a++) begin
      if (a == NA - 1) check("not_cleared_yet", cleared, 0);
      do_hit(START_X + (a % COLS) * SPACING_X + 8, START_Y + (a / COLS) * SPACING_Y + 8);
      check("clear_kill", hit_kill, 1);
      check("clear_index", hit_index, a);
    end
    check("cleared_flag", cleared, 1);
    check("cleared_count", alive_count, 0);
    enable = 1'b1;
    n = 0;
    repeat (100) begin tick(); if (step_pulse) n++; end
    check("cleared_no_steps", n, 0);
    check("cleared_ox", origin_x, START_X);

    // Randomized play with occasional restarts.
    do_restart("restart_d");
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 3) != 0);
      restart   = ($urandom_range(0, 699) == 0);
      hit_valid = ($urandom_range(0, 29) == 0);
      i = int'($urandom_range(0, NA - 1));
      if ($urandom_range(0, 3) != 0) begin
        hit_x = near(m_ox + (i % COLS) * SPACING_X);
        hit_y = near(m_oy + (i / COLS) * SPACING_Y);
      end else begin
        hit_x = 10'($urandom_range(0, 1023));
        hit_y = 10'($urandom_range(0, 1023));
      end
      tick();
    end
    restart = 1'b0; hit_valid = 1'b0; enable = 1'b1;
    do_restart("restart_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
